// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for fifo_rd_stream: FSM state encoding and output buffer depth.
// Also used by the stream_skid_buf occupancy checks.
package fifo_rd_stream_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [1:0] BUF_DEPTH = 2'd2;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order output buffer with flow-through: an empty buffer presents the incoming word at once.
// Zero-cycle bypass when empty; the caller guarantees never to push into a full buffer.
module stream_skid_buf #(
   parameter int W = 65
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_vld_i,
   input  logic [W-1:0] in_dat_i,
   output logic         out_vld_o,
   input  logic         out_rdy_i,
   output logic [W-1:0] out_dat_o,
   output logic [1:0]   count_o
);

   logic [1:0]   cnt_q, cnt_d;
   logic [W-1:0] e0_q, e0_d;
   logic [W-1:0] e1_q, e1_d;
   logic [1:0]   widx;
   logic         deq;

   assign out_vld_o = (cnt_q != 2'd0) || in_vld_i;
   assign out_dat_o = (cnt_q != 2'd0) ? e0_q : in_dat_i;
   assign deq       = out_vld_o && out_rdy_i;
   assign count_o   = cnt_q;

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q + {1'b0, in_vld_i} - {1'b0, deq};
      widx  = cnt_q - {1'b0, deq};
      if (deq) begin
         e0_d = e1_q;
      end
      // A word consumed straight through the bypass is never stored.
      if (in_vld_i && !((cnt_q == 2'd0) && deq)) begin
         if (widx == 2'd0) begin
            e0_d = in_dat_i;
         end else begin
            e1_d = in_dat_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 2'd0;
         e0_q  <= '0;
         e1_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         e0_q  <= e0_d;
         e1_q  <= e1_d;
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Reads bursts of req_len words from a registered-output FIFO into a valid/ready stream; FIFO_RD_STREAM_STALL_CNT_EN adds a starvation counter.
// Accept-to-pop 1 cycle, pop-to-beat 1 cycle; pops throttle so popped-but-unaccepted words never exceed the buffer depth.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 4,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [LEN_WIDTH-1:0]  req_len,
   output logic                  fifo_pop,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   input  logic [ADDR_WIDTH:0]   fifo_count,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  done,
   output logic [15:0]           stall_cycles
);

   logic [1:0]           state_q, state_d;
   logic [LEN_WIDTH-1:0] pop_rem_q, pop_rem_d;
   logic                 inflt_q, inflt_last_q;
   logic                 done_q;
   logic [1:0]           buf_cnt;
   logic                 sb_vld;
   logic [DATA_WIDTH:0]  sb_dat;
   logic                 pop, last_hs;
   logic                 unused_count;

   assign unused_count = ^fifo_count;

   // Occupancy includes the word still on its way out of the FIFO.
   assign pop = !reset && (state_q == ST_RUN) && !fifo_empty && (pop_rem_q != '0)
             && ((buf_cnt + {1'b0, inflt_q}) < BUF_DEPTH);

   stream_skid_buf #(
      .W (DATA_WIDTH + 1)
   ) u_obuf (
      .clk       (clk),
      .reset     (reset),
      .in_vld_i  (inflt_q),
      .in_dat_i  ({inflt_last_q, fifo_data}),
      .out_vld_o (sb_vld),
      .out_rdy_i (m_ready),
      .out_dat_o (sb_dat),
      .count_o   (buf_cnt)
   );

   assign fifo_pop  = pop;
   assign req_ready = reset || (state_q == ST_IDLE);
   assign m_valid   = !reset && sb_vld;
   assign m_data    = m_valid ? sb_dat[DATA_WIDTH-1:0] : '0;
   assign m_last    = m_valid && sb_dat[DATA_WIDTH];
   assign last_hs   = m_valid && m_ready && m_last;
   assign done      = !reset && (done_q || ((state_q == ST_DRAIN) && last_hs));

   always_comb begin
      state_d   = state_q;
      pop_rem_d = pop_rem_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && (req_len != '0)) begin
               state_d   = ST_RUN;
               pop_rem_d = req_len;
            end
         end
         ST_RUN: begin
            if (pop) begin
               pop_rem_d = pop_rem_q - LEN_WIDTH'(1);
               if (pop_rem_q == LEN_WIDTH'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (last_hs) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pop_rem_q    <= '0;
         inflt_q      <= 1'b0;
         inflt_last_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pop_rem_q    <= pop_rem_d;
         inflt_q      <= pop;
         inflt_last_q <= pop && (pop_rem_q == LEN_WIDTH'(1));
         done_q       <= (state_q == ST_IDLE) && req_valid && (req_len == '0);
      end
   end

`ifdef FIFO_RD_STREAM_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= 16'd0;
      end else if ((state_q == ST_IDLE) && req_valid) begin
         stall_q <= 16'd0;
      end else if ((state_q == ST_RUN) && fifo_empty && (pop_rem_q != '0)
                   && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cycles = reset ? 16'd0 : stall_q;
`else
   assign stall_cycles = 16'd0;
`endif

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, data word width; must equal the attached FIFO's width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, attached FIFO address width; fifo_count is ADDR_WIDTH+1 bits.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, burst length field width.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  burst request offered.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-008 req_len  input  LEN_WIDTH  words in burst, unsigned; 0 is legal.
REQ-009 fifo_pop  output  1  pop strobe to FIFO.
REQ-010 fifo_data  input  DATA_WIDTH  FIFO registered read data; valid the cycle after an effective pop, held until the next pop.
REQ-011 fifo_empty  input  1  FIFO empty flag.
REQ-012 fifo_count  input  ADDR_WIDTH+1  FIFO occupancy, observed only.
REQ-013 m_valid  output  1  output beat valid.
REQ-014 m_ready  input  1  downstream accepts beat.
REQ-015 m_data  output  DATA_WIDTH  beat data.
REQ-016 m_last  output  1  final beat of burst.
REQ-017 done  output  1  one-cycle pulse at burst completion.
REQ-018 stall_cycles  output  16  FIFO-starvation counter, see Configuration.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN. req_ready=1 only in IDLE.
REQ-020 IDLE, accept with req_len>0: load pop_remaining=req_len and beat_remaining=req_len, go RUN.
REQ-021 IDLE, accept with req_len=0: stay IDLE, pulse done next cycle, emit no beat.
REQ-022 RUN: fifo_pop=1 iff !fifo_empty && pop_remaining>0 && (buffered+in_flight)<2. Each pop decrements pop_remaining.
REQ-023 SHALL never assert fifo_pop while fifo_empty=1.
REQ-024 Capture fifo_data exactly one cycle after each pop into a 2-entry output buffer. Buffer is in-order; no beat is lost or duplicated under any m_ready pattern.
REQ-025 RUN goes to DRAIN in the cycle after the last pop is issued.
REQ-026 DRAIN goes to IDLE when the beat with m_last=1 is accepted. done pulses in that same cycle.
REQ-027 m_last=1 iff the head beat is the final beat (beat_remaining==1).
REQ-028 m_valid/m_data/m_last SHALL stay stable while m_valid && !m_ready.
REQ-029 Throughput: with the FIFO non-empty and m_ready=1, one beat per cycle after a 2-cycle startup (accept to first pop 1 cycle, pop to m_valid 1 cycle).
REQ-030 fifo_empty during RUN: pops pause and resume without loss when the FIFO refills.
REQ-031 Simultaneous buffer capture and m_ready handshake SHALL keep occupancy unchanged.

Reset
REQ-032 reset SHALL force IDLE and clear counters, the buffer and in-flight tracking.
REQ-033 Outputs during and after reset: m_valid=0, m_data=0, m_last=0, fifo_pop=0, done=0, req_ready=1, stall_cycles=0.
REQ-034 Reset mid-burst SHALL abandon the burst with no further pops or beats. A pop in flight at reset is discarded.

Configuration
REQ-035 Macro FIFO_RD_STREAM_STALL_CNT_EN SHALL control the stall counter.
REQ-036 With FIFO_RD_STREAM_STALL_CNT_EN defined, stall_cycles increments each cycle in RUN with fifo_empty=1 && pop_remaining>0. It saturates at 16'hFFFF and clears on reset or on request accept.
REQ-037 Without FIFO_RD_STREAM_STALL_CNT_EN, stall_cycles SHALL be constant 0 and no counter logic is built.

Structure
REQ-038 Package fifo_rd_stream_pkg SHALL hold the state enumeration (IDLE, RUN, DRAIN) and the buffer-depth constant (2).
REQ-039 The 2-entry output buffer SHALL be a sub-module, stream_skid_buf, parameterised by DATA_WIDTH+1 (data plus last).

Verification
REQ-040 Preload FIFO with 4 words A..D, req_len=4, m_ready=1: beats A,B,C,D on 4 consecutive cycles; m_last only on D; done with D; exactly 4 pops.
REQ-041 req_len=0 accepted: no pops, no m_valid, done one cycle after accept, req_ready stays 1.
REQ-042 req_len=3, FIFO holds 1 word, 2 more pushed 5 cycles later: no pop while empty; 3 ordered beats; stall_cycles=5 with the macro, 0 without.
REQ-043 req_len=6, full FIFO, m_ready toggling 1/0 per cycle: 6 ordered beats, data held stable while stalled, at most 2 buffered.
REQ-044 Reset asserted after the 2nd of 5 beats: next cycle m_valid=0, fifo_pop=0, req_ready=1; a new req_len=2 completes normally.
